// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1 serial receive deframer with a one-byte holding register.
// Latency: rx_valid, frame_error or overrun appear 1 clk after the mid-stop-bit sample.
// Backpressure: one byte is held until rx_valid && rx_ready. A good frame that arrives while it is still held is dropped and flagged with overrun.
//
// Ports:
//   clk, reset_n        system clock and asynchronous active-low reset
//   ena                 enable; low parks the receiver in IDLE and drops any partial frame
//   rx_signal           asynchronous serial line, idle high
//   rx_data/rx_valid    held byte and its valid flag; data stays stable while valid is high
//   rx_ready            consumer accept
//   frame_error         1-cycle pulse when the stop bit is sampled low
//   overrun             1-cycle pulse when a good byte is lost because the holding register is full
module uart_rx_deframer #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115_200,
  parameter int CLK_FREQ   = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ena,
  input  logic                  rx_signal,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TW           = $clog2(CLKS_PER_BIT);
  localparam int IW           = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] T_HALF   = TW'(HALF_BIT - 1);
  localparam logic [TW-1:0] T_FULL   = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  rx_meta, rxs;
  logic                  good_stop, bad_stop;
  logic                  take;

  // Two-flop synchronizer; reset to the idle (high) line level so that
  // reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_signal;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    good_stop = 1'b0;
    bad_stop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        idx_d   = '0;
        if (!rxs) state_d = ST_START;
      end

      // Half a bit into the start bit: a line that is already high again
      // was only a glitch and is ignored without flags.
      ST_START: begin
        if (timer_q == T_HALF) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = rxs ? ST_IDLE : ST_DATA;
        end
      end

      // LSB first: shift right and insert at the MSB, so after the last
      // bit the first received bit sits at bit 0.
      ST_DATA: begin
        if (timer_q == T_FULL) begin
          timer_d = '0;
          shift_d = {rxs, shift_q[DATA_WIDTH-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_STOP;
          end
        end
      end

      ST_STOP: begin
        if (timer_q == T_FULL) begin
          timer_d = '0;
          if (rxs) begin
            good_stop = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            bad_stop = 1'b1;
            state_d  = ST_BREAK;
          end
        end
      end

      // A line held low after a bad stop (break) must return high before
      // the next falling edge can count as a start bit.
      ST_BREAK: begin
        timer_d = '0;
        if (rxs) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        idx_d   = '0;
      end
    endcase

    if (!ena) begin
      state_d   = ST_IDLE;
      timer_d   = '0;
      idx_d     = '0;
      good_stop = 1'b0;
      bad_stop  = 1'b0;
    end
  end

  assign take = rx_valid && rx_ready;

  // The holding register decides on the stop-sample cycle, so the byte or
  // the flag shows up on the next cycle. A byte consumed on that same cycle
  // frees the slot for the new one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= bad_stop;
      overrun     <= 1'b0;
      if (good_stop && (!rx_valid || take)) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else begin
        if (good_stop) overrun  <= 1'b1;
        if (take)      rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at 10 clocks per bit.
// Raw line driven right after a clock edge: rxs falls 2 edges later, stop sample is
// on the 98th edge after the start bit is driven, and outputs are visible after that edge.
module tb_uart_rx_deframer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ena;
  logic       rx_signal;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_error;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  int         cyc = 0;
  logic [7:0] got_q[$];
  int         n_fe = 0;
  int         n_ov = 0;
  int         rise_cyc = -1;
  int         fe_cyc = -1;
  int         ov_cyc = -1;
  logic       prev_v = 1'b0;
  int         t0;

  uart_rx_deframer #(
    .DATA_WIDTH(8),
    .BAUD_RATE (100_000),
    .CLK_FREQ  (1_000_000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ena        (ena),
    .rx_signal  (rx_signal),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_error(frame_error),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_valid && !prev_v) begin
      got_q.push_back(rx_data);
      rise_cyc = cyc;
    end
    if (frame_error) begin
      n_fe++;
      fe_cyc = cyc;
    end
    if (overrun) begin
      n_ov++;
      ov_cyc = cyc;
    end
    prev_v = rx_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives start, 8 data bits LSB first and the stop bit, 10 clocks each.
  // rdy_at >= 0 pulses rx_ready for the single cycle after that many ticks.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int rdy_at);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int k = 0; k < 100; k++) begin
      rx_signal = bits[k/10];
      if (rdy_at >= 0) rx_ready = (k == rdy_at);
      tick();
    end
  endtask

  task automatic idle(input int n);
    rx_signal = 1'b1;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    // ---- reset ----
    reset_n   = 1'b0;
    ena       = 1'b1;
    rx_signal = 1'b1;
    rx_ready  = 1'b0;
    tick(); tick(); tick();
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_frame_error", frame_error, 0);
    check("reset_overrun", overrun, 0);
    reset_n = 1'b1;
    idle(5);

    // ---- single frame 0xA5, consumer not ready ----
    got_q.delete();
    t0 = cyc;
    send_frame(8'hA5, 1'b1, -1);
    idle(5);
    check("a5_count", got_q.size(), 1);
    check("a5_rise_cycle", rise_cyc, t0 + 98);
    check("a5_data", rx_data, 8'hA5);
    check("a5_valid_held", rx_valid, 1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("a5_valid_cleared", rx_valid, 0);
    check("a5_no_fe", n_fe, 0);
    check("a5_no_ov", n_ov, 0);

    // ---- back-to-back 0x00, 0xFF, 0x3C with ready held ----
    got_q.delete();
    rx_ready = 1'b1;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    send_frame(8'h3C, 1'b1, -1);
    idle(20);
    rx_ready = 1'b0;
    check("b2b_count", got_q.size(), 3);
    check("b2b_data0", got_q[0], 8'h00);
    check("b2b_data1", got_q[1], 8'hFF);
    check("b2b_data2", got_q[2], 8'h3C);
    check("b2b_no_fe", n_fe, 0);
    check("b2b_no_ov", n_ov, 0);
    check("b2b_valid_cleared", rx_valid, 0);

    // ---- bad stop on 0x55, line held low, then 0x12 ----
    got_q.delete();
    t0 = cyc;
    send_frame(8'h55, 1'b0, -1);
    rx_signal = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    idle(20);
    check("fe_count", n_fe, 1);
    check("fe_cycle", fe_cyc, t0 + 98);
    check("fe_no_valid", got_q.size(), 0);
    check("fe_no_ov", n_ov, 0);
    send_frame(8'h12, 1'b1, -1);
    idle(5);
    check("after_break_count", got_q.size(), 1);
    check("after_break_data", rx_data, 8'h12);
    check("after_break_fe", n_fe, 1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;

    // ---- 3-cycle glitch on idle line ----
    got_q.delete();
    rx_signal = 1'b0;
    tick(); tick(); tick();
    idle(40);
    check("glitch_no_valid", got_q.size(), 0);
    check("glitch_valid_low", rx_valid, 0);
    check("glitch_no_fe", n_fe, 1);
    check("glitch_no_ov", n_ov, 0);

    // ---- overrun: 0x11 held, 0x22 dropped ----
    got_q.delete();
    send_frame(8'h11, 1'b1, -1);
    idle(5);
    check("ov_first_data", rx_data, 8'h11);
    t0 = cyc;
    send_frame(8'h22, 1'b1, -1);
    idle(5);
    check("ov_count", n_ov, 1);
    check("ov_cycle", ov_cyc, t0 + 98);
    check("ov_data_kept", rx_data, 8'h11);
    check("ov_valid_kept", rx_valid, 1);

    // ---- 0x22 again, consumer accepts 0x11 on the delivery decision cycle ----
    send_frame(8'h22, 1'b1, 97);
    check("ready_in_time_data", rx_data, 8'h22);
    check("ready_in_time_valid", rx_valid, 1);
    idle(5);
    check("ready_in_time_no_ov", n_ov, 1);
    check("ready_in_time_rises", got_q.size(), 1);

    // ---- reset in the middle of data bit 4 of 0x77 (0x22 still held) ----
    for (int k = 0; k < 55; k++) begin
      rx_signal = (k < 10) ? 1'b0 : ((8'h77 >> ((k / 10) - 1)) & 1) != 0;
      tick();
    end
    reset_n = 1'b0;
    #1;
    check("midreset_valid", rx_valid, 0);
    check("midreset_data", rx_data, 0);
    check("midreset_fe", frame_error, 0);
    check("midreset_ov", overrun, 0);
    rx_signal = 1'b1;
    tick(); tick(); tick();
    reset_n = 1'b1;
    idle(5);
    got_q.delete();
    t0 = cyc;
    send_frame(8'h99, 1'b1, -1);
    idle(5);
    check("post_reset_count", got_q.size(), 1);
    check("post_reset_cycle", rise_cyc, t0 + 98);
    check("post_reset_data", rx_data, 8'h99);
    check("post_reset_no_fe", n_fe, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
